// File: rtl/sys_tick_pkg.sv
// sys_tick_pkg
// Shared definitions for the sys_tick_scheduler block:
//   - sys_clk_timer register addresses
//   - control register bit positions and the run command word
//   - scheduler FSM state encoding
package sys_tick_pkg;

  // sys_clk_timer register map
  localparam logic [2:0] TMR_STATUS   = 3'd0;
  localparam logic [2:0] TMR_CONTROL  = 3'd1;
  localparam logic [2:0] TMR_PERIOD_L = 3'd2;
  localparam logic [2:0] TMR_PERIOD_H = 3'd3;

  // Control register bit positions
  typedef enum int {
    CTL_ITO   = 0,
    CTL_CONT  = 1,
    CTL_START = 2,
    CTL_STOP  = 3
  } ctl_bit_e;

  // Interrupt enable + continuous + start
  localparam logic [15:0] CTL_RUN = 16'h0007;

  // ST_RESET only exists while reset_n is low, so the bus is quiet during
  // reset and the first init write lands one cycle after release.
  typedef enum logic [3:0] {
    ST_RESET    = 4'd0,
    ST_INIT_PL  = 4'd1,
    ST_INIT_PH  = 4'd2,
    ST_INIT_CTL = 4'd3,
    ST_IDLE     = 4'd4,
    ST_ACK      = 4'd5,
    ST_TICK     = 4'd6,
    ST_RP_L     = 4'd7,
    ST_RP_H     = 4'd8,
    ST_RP_CTL   = 4'd9
  } state_t;

endpackage

// File: rtl/sys_tick_channel.sv
// sys_tick_channel
// One divided tick channel: a down-counter that fires on every div-th base
// tick, a pending flag held until acknowledged, and an optional sticky
// overrun flag (built only when TICK_OVERRUN_EN is defined).
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   fire_en        one-cycle base tick strobe (scheduler TICK state)
//   div            divisor; 0 disables the channel
//   tick_ack       clears tick_pending
//   tick_pending   level tick request to the consumer
//   overrun        sticky: fired while the previous tick was still pending
module sys_tick_channel
  import sys_tick_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             fire_en,
  input  logic [DIV_W-1:0] div,
  input  logic             tick_ack,
  output logic             tick_pending,
  output logic             overrun
);

  logic [DIV_W-1:0] count_r;
  logic             fire_s;

  // A zero counter means "fire on this base tick"; reset therefore makes the
  // first base tick fire every enabled channel.
  assign fire_s = fire_en && (div != '0) && (count_r == '0);

  // Divider counter; div is sampled only at reload, so a new divisor
  // takes effect after the current interval completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
    end else if (fire_en) begin
      if (div == '0) begin
        count_r <= '0;
      end else if (count_r == '0) begin
        count_r <= div - DIV_W'(1);
      end else begin
        count_r <= count_r - DIV_W'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

  // Pending flag; a fire wins over a coincident ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_pending <= 1'b0;
    end else if (fire_s) begin
      tick_pending <= 1'b1;
    end else if (tick_ack) begin
      tick_pending <= 1'b0;
    end else begin
      tick_pending <= tick_pending;
    end
  end

`ifdef TICK_OVERRUN_EN
  // Overrun flag: set on fire into an unacked pending tick, cleared by an
  // ack in a cycle with no fire.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (fire_s && tick_pending && !tick_ack) begin
      overrun <= 1'b1;
    end else if (tick_ack && !fire_s) begin
      overrun <= 1'b0;
    end else begin
      overrun <= overrun;
    end
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: rtl/sys_tick_scheduler.sv
// sys_tick_scheduler
// Avalon-MM master that owns the sys_clk_timer slave: programs the timer for
// continuous interrupts after reset, services each interrupt (status clear),
// fans the base tick out to NUM_CH divided channels and sequences runtime
// period changes. Optional overrun detection: define TICK_OVERRUN_EN.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   av_address/chipselect/write_n/writedata   timer write port (Moore decoded)
//   timer_irq             timer interrupt, sticky until status write
//   period_req/value/ack  period change handshake (ack = one-cycle pulse)
//   chan_div              per-channel divisors, channel i at [i*DIV_W +: DIV_W]
//   tick_pending/ack      per-channel tick level and acknowledge
//   overrun               per-channel sticky overrun
//   busy                  FSM not idle
module sys_tick_scheduler
  import sys_tick_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          DIV_W       = 8,
  parameter logic [31:0] INIT_PERIOD = 32'd499999
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic [2:0]              av_address,
  output logic                    av_chipselect,
  output logic                    av_write_n,
  output logic [15:0]             av_writedata,
  input  logic                    timer_irq,
  input  logic                    period_req,
  input  logic [31:0]             period_value,
  output logic                    period_ack,
  input  logic [NUM_CH*DIV_W-1:0] chan_div,
  output logic [NUM_CH-1:0]       tick_pending,
  input  logic [NUM_CH-1:0]       tick_ack,
  output logic [NUM_CH-1:0]       overrun,
  output logic                    busy
);

  state_t      state_r;
  state_t      state_s;
  logic [31:0] period_r;
  logic        accept_s;
  logic        fire_en_s;

  // Interrupt service has priority; a request waits while the irq is up.
  assign accept_s  = (state_r == ST_IDLE) && !timer_irq && period_req;
  assign fire_en_s = (state_r == ST_TICK);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_RESET;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and Moore-decoded bus / handshake outputs
  always_comb begin
    state_s       = state_r;
    av_chipselect = 1'b0;
    av_write_n    = 1'b1;
    av_address    = 3'd0;
    av_writedata  = 16'd0;
    period_ack    = 1'b0;
    busy          = 1'b1;
    case (state_r)
      ST_RESET: begin
        state_s = ST_INIT_PL;
      end
      ST_INIT_PL: begin
        state_s       = ST_INIT_PH;
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = TMR_PERIOD_L;
        av_writedata  = INIT_PERIOD[15:0];
      end
      ST_INIT_PH: begin
        state_s       = ST_INIT_CTL;
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = TMR_PERIOD_H;
        av_writedata  = INIT_PERIOD[31:16];
      end
      ST_INIT_CTL: begin
        state_s       = ST_IDLE;
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = TMR_CONTROL;
        av_writedata  = CTL_RUN;
      end
      ST_IDLE: begin
        busy = 1'b0;
        if (timer_irq) begin
          state_s = ST_ACK;
        end else if (period_req) begin
          state_s = ST_RP_L;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACK: begin
        state_s       = ST_TICK;
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = TMR_STATUS;
        av_writedata  = 16'd0;
      end
      ST_TICK: begin
        state_s = ST_IDLE;
      end
      ST_RP_L: begin
        state_s       = ST_RP_H;
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = TMR_PERIOD_L;
        av_writedata  = period_r[15:0];
      end
      ST_RP_H: begin
        state_s       = ST_RP_CTL;
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = TMR_PERIOD_H;
        av_writedata  = period_r[31:16];
      end
      ST_RP_CTL: begin
        state_s       = ST_IDLE;
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = TMR_CONTROL;
        av_writedata  = CTL_RUN;
        period_ack    = 1'b1;
      end
      default: begin
        state_s = ST_RESET;
      end
    endcase
  end

  // Period capture on the IDLE->RP_L edge; the requester may change
  // period_value afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_r <= 32'd0;
    end else if (accept_s) begin
      period_r <= period_value;
    end else begin
      period_r <= period_r;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sys_tick_channel #(
      .DIV_W(DIV_W)
    ) u_channel (
      .clk         (clk),
      .reset_n     (reset_n),
      .fire_en     (fire_en_s),
      .div         (chan_div[i*DIV_W +: DIV_W]),
      .tick_ack    (tick_ack[i]),
      .tick_pending(tick_pending[i]),
      .overrun     (overrun[i])
    );
  end

endmodule

// File: tb/tb_sys_tick_scheduler.sv
// tb_sys_tick_scheduler
// Directed bench for sys_tick_scheduler. Each stimulus step states the bus
// cycle the timer map requires; a tick-number model (next fire = last fire +
// divisor) predicts channel pending/overrun. A negedge process compares all
// outputs every cycle; literal checks pin the model at key points.
module tb_sys_tick_scheduler;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;
`ifdef TICK_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [2:0]              av_address;
  logic                    av_chipselect;
  logic                    av_write_n;
  logic [15:0]             av_writedata;
  logic                    timer_irq;
  logic                    period_req;
  logic [31:0]             period_value;
  logic                    period_ack;
  logic [NUM_CH*DIV_W-1:0] chan_div;
  logic [NUM_CH-1:0]       tick_pending;
  logic [NUM_CH-1:0]       tick_ack;
  logic [NUM_CH-1:0]       overrun;
  logic                    busy;

  sys_tick_scheduler #(
    .NUM_CH(NUM_CH),
    .DIV_W (DIV_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .av_address   (av_address),
    .av_chipselect(av_chipselect),
    .av_write_n   (av_write_n),
    .av_writedata (av_writedata),
    .timer_irq    (timer_irq),
    .period_req   (period_req),
    .period_value (period_value),
    .period_ack   (period_ack),
    .chan_div     (chan_div),
    .tick_pending (tick_pending),
    .tick_ack     (tick_ack),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // expected bus cycle
  logic        e_wr;
  logic [2:0]  e_addr;
  logic [15:0] e_data;
  logic        e_ack;
  logic        e_busy;

  // channel model: base tick number and the tick number of each next fire
  logic              m_tick;
  int                k;
  int                next_fire [NUM_CH];
  logic [NUM_CH-1:0] m_pend;
  logic [NUM_CH-1:0] m_ovr;

  // observation counters for literal pins
  logic              cnt_en;
  int                rise_cnt [NUM_CH];
  int                ack_cnt;
  logic [NUM_CH-1:0] prev_pend;

  function automatic logic [DIV_W-1:0] div_of(input int i);
    return chan_div[i*DIV_W +: DIV_W];
  endfunction

  function automatic bit fires(input int i, input int kk);
    return (div_of(i) != 8'd0) && (kk == next_fire[i]);
  endfunction

  // channel model update
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k      <= 0;
      m_pend <= '0;
      m_ovr  <= '0;
      for (int i = 0; i < NUM_CH; i++) next_fire[i] <= 1;
    end else begin
      if (m_tick) k <= k + 1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (m_tick) begin
          if (div_of(i) == 8'd0) next_fire[i] <= k + 2;
          else if (fires(i, k + 1)) next_fire[i] <= k + 1 + int'(div_of(i));
        end
        if (m_tick && fires(i, k + 1)) m_pend[i] <= 1'b1;
        else if (tick_ack[i]) m_pend[i] <= 1'b0;
`ifdef TICK_OVERRUN_EN
        if (m_tick && fires(i, k + 1) && m_pend[i] && !tick_ack[i]) m_ovr[i] <= 1'b1;
        else if (tick_ack[i] && !(m_tick && fires(i, k + 1))) m_ovr[i] <= 1'b0;
`endif
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // per-cycle compare
  initial begin
    prev_pend = '0;
    ack_cnt   = 0;
    for (int i = 0; i < NUM_CH; i++) rise_cnt[i] = 0;
    forever begin
      @(negedge clk);
      check("chipselect", 32'(av_chipselect), 32'(e_wr));
      check("write_n", 32'(av_write_n), 32'(!e_wr));
      check("address", 32'(av_address), 32'(e_addr));
      check("writedata", 32'(av_writedata), 32'(e_data));
      check("period_ack", 32'(period_ack), 32'(e_ack));
      check("busy", 32'(busy), 32'(e_busy));
      check("tick_pending", 32'(tick_pending), 32'(m_pend));
      check("overrun", 32'(overrun), 32'(m_ovr));
      if (cnt_en) begin
        for (int i = 0; i < NUM_CH; i++)
          if (tick_pending[i] && !prev_pend[i]) rise_cnt[i]++;
      end
      if (period_ack === 1'b1) ack_cnt++;
      prev_pend = tick_pending;
    end
  end

  // advance one cycle and state the expected bus cycle; per-cycle inputs
  // default to inactive
  task automatic cyc(input logic wr, input logic [2:0] a, input logic [15:0] d,
                     input logic ack, input logic bsy);
    @(posedge clk);
    #1;
    e_wr = wr; e_addr = a; e_data = d; e_ack = ack; e_busy = bsy;
    m_tick = 1'b0; tick_ack = '0; timer_irq = 1'b0;
  endtask

  task automatic wr_cyc(input logic [2:0] a, input logic [15:0] d, input logic ack);
    cyc(1'b1, a, d, ack, 1'b1);
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic reset_exp();
    e_wr = 1'b0; e_addr = 3'd0; e_data = 16'd0; e_ack = 1'b0; e_busy = 1'b1;
  endtask

  task automatic init_seq();
    wr_cyc(3'd2, 16'hA11F, 1'b0);
    wr_cyc(3'd3, 16'h0007, 1'b0);
    wr_cyc(3'd1, 16'h0007, 1'b0);
  endtask

  // irq in idle cycle N, ACK in N+1, TICK in N+2
  task automatic service(input logic ack_imm, input logic [NUM_CH-1:0] ack_t);
    idle_cyc();
    timer_irq = 1'b1;
    tick_ack  = ack_imm ? m_pend : '0;
    wr_cyc(3'd0, 16'd0, 1'b0);
    cyc(1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
    m_tick   = 1'b1;
    tick_ack = ack_t;
  endtask

  initial begin
    reset_n = 1'b0; timer_irq = 1'b0; period_req = 1'b0; period_value = 32'd0;
    tick_ack = '0; m_tick = 1'b0; cnt_en = 1'b0;
    chan_div = {8'd0, 8'd3, 8'd1, 8'd2};
    reset_exp();

    // reset and init sequence
    repeat (2) cyc(1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
    check("reset_pending", 32'(tick_pending), 32'd0);
    reset_n = 1'b1;
    init_seq();

    // six services with immediate acks
    cnt_en = 1'b1;
    for (int n = 0; n < 6; n++) service(1'b1, '0);
    idle_cyc();
    tick_ack = m_pend;
    idle_cyc();
    cnt_en = 1'b0;
    check("rise_ch0", 32'(rise_cnt[0]), 32'd3);
    check("rise_ch1", 32'(rise_cnt[1]), 32'd6);
    check("rise_ch2", 32'(rise_cnt[2]), 32'd2);
    check("rise_ch3", 32'(rise_cnt[3]), 32'd0);

    // irq and period request in the same cycle
    idle_cyc();
    timer_irq = 1'b1; period_req = 1'b1; period_value = 32'h0001_86A0;
    wr_cyc(3'd0, 16'd0, 1'b0);
    cyc(1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
    m_tick = 1'b1;
    idle_cyc();
    tick_ack = m_pend;
    wr_cyc(3'd2, 16'h86A0, 1'b0);
    period_value = 32'hDEAD_BEEF;
    wr_cyc(3'd3, 16'h0001, 1'b0);
    wr_cyc(3'd1, 16'h0007, 1'b1);
    idle_cyc();
    period_req = 1'b0;
    tick_ack = m_pend;
    chan_div = {8'd0, 8'd0, 8'd1, 8'd0};
    check("ack_count_rp", 32'(ack_cnt), 32'd1);

    // ch1 div=1, two unacked services
    service(1'b0, '0);
    service(1'b0, '0);
    idle_cyc();
    check("hold_pending1", 32'(tick_pending[1]), 32'd1);
    check("hold_overrun1", 32'(overrun[1]), 32'(OVR_EXP));
    tick_ack = 4'b0010;
    idle_cyc();
    check("clr_pending1", 32'(tick_pending[1]), 32'd0);
    check("clr_overrun1", 32'(overrun[1]), 32'd0);
    chan_div = {8'd0, 8'd0, 8'd0, 8'd1};

    // ch0 ack coinciding with fire
    service(1'b0, '0);
    service(1'b0, 4'b0001);
    idle_cyc();
    check("coinc_pending0", 32'(tick_pending[0]), 32'd1);
    check("coinc_overrun0", 32'(overrun[0]), 32'd0);
    tick_ack = m_pend;

    // reset pulsed during RP_H
    idle_cyc();
    period_req = 1'b1; period_value = 32'h1234_5678;
    wr_cyc(3'd2, 16'h5678, 1'b0);
    wr_cyc(3'd3, 16'h1234, 1'b0);
    reset_n = 1'b0; period_req = 1'b0;
    reset_exp();
    cyc(1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
    check("midrst_busy", 32'(busy), 32'd1);
    cyc(1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
    reset_n = 1'b1;
    init_seq();
    repeat (3) idle_cyc();
    @(negedge clk);
    #1;
    check("ack_count_end", 32'(ack_cnt), 32'd1);
    check("end_pending", 32'(tick_pending), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sys_tick_scheduler.md
# sys_tick_scheduler

Avalon-MM master controller that owns the `sys_clk_timer` slave port. After reset it programs the timer for continuous interrupts. It services every timer interrupt and clears the timer's status bit, then fans the base tick out to NUM_CH independently divided tick channels. It also accepts runtime period-change requests and sequences the required timer register writes. It sits between `sys_clk_timer` and the tick consumers (frame pacing, debounce, watchdog kick).

## Interface
- NUM_CH, 4, number of divided tick channels (1..16)
- DIV_W, 8, width of each channel divisor
- INIT_PERIOD, 499999, 32-bit period written at init (10 ms at 50 MHz; interval = value+1 clocks)

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- av_address  out  3  timer register address
- av_chipselect  out  1  timer select, asserted only on write cycles
- av_write_n  out  1  active-low write strobe
- av_writedata  out  16  timer write data
- timer_irq  in  1  timer interrupt (level, sticky until status write)
- period_req  in  1  request new timer period; hold until period_ack
- period_value  in  32  new period, captured in the accept cycle
- period_ack  out  1  one-cycle pulse: reprogram complete
- chan_div  in  NUM_CH*DIV_W  per-channel divisor, channel i at [i*DIV_W +: DIV_W]
- tick_pending  out  NUM_CH  per-channel tick, level until acked
- tick_ack  in  NUM_CH  per-channel acknowledge (clears pending)
- overrun  out  NUM_CH  sticky: tick fired while still pending
- busy  out  1  FSM not in IDLE

## Operation
- Timer map used: 0 status (any write clears TO), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 period_l, 3 period_h.
- Bus signals are Moore-decoded from the state register. Each write takes exactly one cycle; no waitrequest. In non-write states: chipselect=0, write_n=1, address=0, writedata=0.
- States and writes:
  - INIT_PL: write addr 2 ← INIT_PERIOD[15:0].
  - INIT_PH: write addr 3 ← INIT_PERIOD[31:16].
  - INIT_CTL: write addr 1 ← 16'h0007.
  - IDLE: no write.
  - ACK: write addr 0 ← 0.
  - TICK: no write.
  - RP_L: write addr 2 ← captured value[15:0].
  - RP_H: write addr 3 ← captured value[31:16].
  - RP_CTL: write addr 1 ← 16'h0007.
- Transitions:
  - Reset → INIT_PL → INIT_PH → INIT_CTL → IDLE.
  - IDLE with timer_irq=1 → ACK → TICK → IDLE. The irq has priority over period_req.
  - IDLE with period_req=1 and timer_irq=0 → RP_L → RP_H → RP_CTL → IDLE. period_value is captured on the IDLE→RP_L edge.
- Channel update happens in TICK, once per base tick, for each channel i:
  - div=0: channel disabled; counter held 0, never fires.
  - Otherwise, counter=0: fire and load div-1.
  - Otherwise: decrement.
  - Counters reset to 0, so the first base tick fires every enabled channel. div=1 fires every base tick.
  - A change to chan_div takes effect at the next reload.
- Fire sets tick_pending[i]. tick_ack[i] clears it. If fire and ack coincide, pending stays 1 and no overrun is flagged.
- A timer irq arriving during the RP_* states is not lost. It stays sticky in the timer and is serviced on return to IDLE.
- Reset mid-sequence: all state is discarded and the init sequence restarts. No pending period request is remembered.

## Timing
- Reset values: av_chipselect=0, av_write_n=1, av_address=0, av_writedata=0, period_ack=0, tick_pending=0, overrun=0, busy=1.
- Init: the first write (INIT_PL) occurs in the first cycle after reset release. busy=0 from the 4th cycle.
- Interrupt service: timer_irq high in IDLE cycle N gives the ACK write in N+1 and TICK in N+2. tick_pending is visible in N+3. timer_irq is low by N+2.
- Reprogram: period_req accepted in cycle N gives writes in N+1..N+3. period_ack is high in N+3, concurrent with the RP_CTL write. The requester may drop period_req in N+4.
- Back-to-back: the minimum IDLE dwell between services is 1 cycle.

## Configuration
- TICK_OVERRUN_EN defined:
  - overrun[i] is set when channel i fires while tick_pending[i]=1 and tick_ack[i]=0.
  - It is cleared only by tick_ack[i] in a cycle with no fire.
- TICK_OVERRUN_EN undefined: overrun is tied to 0 and no detection logic is built.

## Structure
- Package sys_tick_pkg holds:
  - timer register addresses (TMR_STATUS=0, TMR_CONTROL=1, TMR_PERIOD_L=2, TMR_PERIOD_H=3);
  - control bit positions and the CTL_RUN=16'h0007 constant;
  - the FSM state enum.
- Sub-module sys_tick_channel: one divider counter plus pending/overrun flags. The top instantiates NUM_CH copies in a generate loop, driven by a common fire-enable from the TICK state.

## Test plan
- Reset release: bus shows writes (2,0xA11F), (3,0x0007), (1,0x0007) on cycles 1–3; busy falls on cycle 4.
- chan_div={0,3,1,2} (ch3..ch0), 6 irq services with immediate acks → ch0 fires on ticks 1,3,5; ch1 on every tick; ch2 on ticks 1,4; ch3 never.
- timer_irq and period_req rise in the same cycle with period_value=0x0001_86A0 → ACK/TICK sequence first, then writes (2,0x86A0), (3,0x0001), (1,0x0007); period_ack pulses exactly once.
- ch1 div=1, tick_ack held low for 2 services → tick_pending[1]=1 throughout; overrun[1]=1 with macro, 0 without; ack then clears both.
- tick_ack[0] asserted in the same cycle ch0 fires → tick_pending[0] stays 1, overrun[0] stays 0.
- reset_n pulsed low during RP_H → outputs return to reset values; init sequence restarts and no period_ack is issued.
